// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Byte-stream program loader; packs little-endian words and writes
//            them into instruction memory. Optional trailing checksum byte
//            enabled by defining INSTR_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader #(
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  WordCount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_len;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word_lo;
  logic [7:0]  r_count;
  logic [31:0] r_wa;
  logic [31:0] r_wd;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic        w_rx_ready;
  logic        w_accept;
  logic        w_start_ok;
  logic        w_len_bad;
  logic [7:0]  w_count_inc;

  always_comb begin
    w_rx_ready = 1'b0;
    case (r_state)
      S_LEN, S_DATA, S_CHK: w_rx_ready = 1'b1;
      default:              w_rx_ready = 1'b0;
    endcase
  end

  assign w_accept    = RxValid && w_rx_ready;
  assign w_start_ok  = Start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERR));
  assign w_len_bad   = (RxData == 8'd0) || ({24'd0, RxData} > c_mem_words);
  assign w_count_inc = r_count + 8'd1;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) w_state_next = S_LEN;
      end
      S_LEN: begin
        if (w_accept) w_state_next = w_len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_count_inc == r_len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          w_state_next = S_CHK;
`else
          w_state_next = S_DONE;
`endif
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (w_accept) w_state_next = (RxData == r_sum) ? S_DONE : S_ERR;
`else
        w_state_next = S_IDLE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // WA/WD are loaded as the 4th byte lands so they are valid throughout WRITE
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_len      <= 8'd0;
      r_byte_idx <= 2'd0;
      r_word_lo  <= 24'd0;
      r_count    <= 8'd0;
      r_wa       <= 32'd0;
      r_wd       <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_sum      <= 8'd0;
`endif
    end else if (w_start_ok) begin
      r_byte_idx <= 2'd0;
      r_count    <= 8'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_sum      <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_LEN: begin
          if (w_accept && !w_len_bad) r_len <= RxData;
        end
        S_DATA: begin
          if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + RxData;
`endif
            case (r_byte_idx)
              2'd0: r_word_lo[7:0]   <= RxData;
              2'd1: r_word_lo[15:8]  <= RxData;
              2'd2: r_word_lo[23:16] <= RxData;
              default: begin
                r_wd <= {RxData, r_word_lo};
                r_wa <= BASE_ADDR + {22'd0, r_count, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: begin
          r_count <= w_count_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign RxReady   = w_rx_ready;
  assign WE        = (r_state == S_WRITE);
  assign WA        = r_wa;
  assign WD        = r_wd;
  assign Busy      = (r_state == S_LEN) || (r_state == S_DATA) ||
                     (r_state == S_WRITE) || (r_state == S_CHK);
  assign Done      = (r_state == S_DONE);
  assign Error     = (r_state == S_ERR);
  assign WordCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Self-checking bench for instr_mem_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

  localparam int          c_mem_words = 128;
  localparam logic [31:0] c_base      = 32'h0000_0000;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  RxData = 8'd0;
  logic        RxValid = 1'b0;
  logic        RxReady;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [7:0]  WordCount;

  int tests = 0;
  int fails = 0;
  logic [63:0] obs_q[$];

  instr_mem_loader #(
    .MEM_WORDS (c_mem_words),
    .BASE_ADDR (c_base)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .WordCount (WordCount)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WE === 1'b1) obs_q.push_back({WA, WD});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t make_frame(input int n, input wq_t words);
    bq_t  fr;
    logic [7:0] sum;
    sum = 8'd0;
    fr.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        fr.push_back(words[i][8*k +: 8]);
        sum = sum + words[i][8*k +: 8];
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    fr.push_back(sum);
`endif
    return fr;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit taken = 1'b0;
    int budget = 0;
    while (!taken && budget < 1000) begin
      @(negedge CLK);
      Start   = 1'b0;
      RxData  = b;
      RxValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (RxValid && RxReady) taken = 1'b1;
      budget++;
    end
    if (!taken) chk("byte_timeout", 64'(taken), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset   = 1'b1;
    Start   = 1'b0;
    RxValid = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge CLK);
    RxValid = 1'b0;
    while (Busy && c < 64) begin
      @(negedge CLK);
      c++;
    end
    chk("idle_timeout", 64'(Busy), 64'd0);
  endtask

  // Drives a whole frame (optionally pulsing Start before byte start_at) and
  // checks every write and the final status against the frame rules.
  task automatic run_frame(input string tag, input bq_t fr, input bit rnd, input int start_at);
    int          n;
    bit          len_bad;
    bit          exp_err;
    logic [63:0] exp_q[$];
    logic [7:0]  sum;
    logic [31:0] w;
    obs_q.delete();
    @(negedge CLK);
    Start = 1'b1;
    for (int i = 0; i < fr.size(); i++) begin
      if (i == start_at) begin
        @(negedge CLK);
        Start   = 1'b1;
        RxValid = 1'b0;
      end
      send_byte(fr[i], rnd);
    end
    wait_idle();

    n       = int'(fr[0]);
    len_bad = (n == 0) || (n > c_mem_words);
    exp_err = len_bad;
    sum     = 8'd0;
    if (!len_bad) begin
      for (int i = 0; i < n; i++) begin
        w = {fr[4*i+4], fr[4*i+3], fr[4*i+2], fr[4*i+1]};
        exp_q.push_back({c_base + 32'(4 * i), w});
        sum = sum + fr[4*i+1] + fr[4*i+2] + fr[4*i+3] + fr[4*i+4];
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_err = (sum != fr[4*n+1]);
`endif
    end

    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) chk({tag, "_write"}, obs_q[i], exp_q[i]);
    end
    chk({tag, "_done"},    64'(Done),      64'(!exp_err));
    chk({tag, "_error"},   64'(Error),     64'(exp_err));
    chk({tag, "_count"},   64'(WordCount), len_bad ? 64'd0 : 64'(n));
    chk({tag, "_rxready"}, 64'(RxReady),   64'd0);
    chk({tag, "_we"},      64'(WE),        64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rxready"}, 64'(RxReady),   64'd0);
    chk({tag, "_we"},      64'(WE),        64'd0);
    chk({tag, "_busy"},    64'(Busy),      64'd0);
    chk({tag, "_done"},    64'(Done),      64'd0);
    chk({tag, "_error"},   64'(Error),     64'd0);
    chk({tag, "_wa"},      64'(WA),        64'd0);
    chk({tag, "_wd"},      64'(WD),        64'd0);
    chk({tag, "_count"},   64'(WordCount), 64'd0);
  endtask

  initial begin
    wq_t  words;
    bq_t  fr;
    int   n;

    do_reset();
    chk_zero("reset");

    // Test-plan frame: two ARM-style words, RxValid held high
    words = '{32'hE3A0_0000, 32'hE281_1001};
    run_frame("basic", make_frame(2, words), 1'b0, -1);

    // Illegal counts are rejected before any data
    fr = '{8'h00};
    run_frame("len0", fr, 1'b0, -1);
    fr = '{8'h81};
    run_frame("len129", fr, 1'b0, -1);

    // Maximum frame, data = word index, random RxValid gaps
    words.delete();
    for (int i = 0; i < c_mem_words; i++) words.push_back(32'(i));
    run_frame("max", make_frame(c_mem_words, words), 1'b1, -1);
    if (obs_q.size() > 0) chk("max_last", obs_q[obs_q.size()-1], {32'h0000_01FC, 32'h0000_007F});

    // Reset after 2 bytes of word 3: no partial write, everything cleared
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    fr = make_frame(3, words);
    obs_q.delete();
    @(negedge CLK);
    Start = 1'b1;
    for (int i = 0; i < 11; i++) send_byte(fr[i], 1'b0);
    @(negedge CLK);
    RxValid = 1'b0;
    Reset   = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("midreset_nwrites", 64'(obs_q.size()), 64'd2);
    chk_zero("midreset");
    words = '{32'hCAFE_F00D};
    run_frame("after_reset", make_frame(1, words), 1'b0, -1);

    // Start pulsed mid-DATA is ignored
    words = '{32'hDEAD_BEEF, 32'h0BAD_C0DE};
    run_frame("start_in_data", make_frame(2, words), 1'b0, 6);

    // Random small frames with random data and valid gaps
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_frame("random", make_frame(n, words), 1'b1, -1);
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    fr = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_frame("csum_good", fr, 1'b0, -1);
    fr = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_frame("csum_bad", fr, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Program loader that writes instruction memory: the write-side counterpart to the read-only instruction fetch path.
- Accepts a byte stream over a valid/ready handshake (from a UART receiver or testbench) and assembles little-endian 32-bit words.
- Issues one write strobe per word to instruction memory, at word-aligned addresses starting at BASE_ADDR.
- Holds Busy high for the whole load so the core can be stalled.

Parameters:
- MEM_WORDS, 128: memory depth in words; the largest legal word count.
- BASE_ADDR, 32'h00000000: byte address of the first word written.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle pulse; begins a load frame; honoured only in IDLE, DONE or ERR.
- RxData  input  8  incoming byte.
- RxValid  input  1  RxData valid.
- RxReady  output  1  loader can accept a byte this cycle.
- WE  output  1  instruction-memory write enable, one cycle per word.
- WA  output  32  write byte address, word aligned.
- WD  output  32  write data.
- Busy  output  1  load in progress.
- Done  output  1  last frame completed successfully; level.
- Error  output  1  last frame rejected; level.
- WordCount  output  8  words written in the current or last frame.

Behaviour:
- Byte transfer occurs only when RxValid and RxReady are both high on a rising edge. Bytes presented while RxReady is low are not consumed.
- Reset (any state, including mid-frame) forces:
  - state IDLE;
  - RxReady, WE, Busy, Done, Error = 0;
  - WA, WD = 0; WordCount = 0.
  - A partially assembled word is discarded and never written.
- States: IDLE, LEN, DATA, WRITE, CHK (macro only), DONE, ERR.
- IDLE / DONE / ERR, Start=1:
  - go to LEN; clear Done, Error and WordCount; byte index = 0; Busy = 1.
  - Start in any other state is ignored.
- LEN (RxReady=1): the accepted byte is N, the word count.
  - N=0 or N>MEM_WORDS: go to ERR.
  - Otherwise: latch N, go to DATA.
- DATA (RxReady=1):
  - Byte k of a word (k=0..3) goes into bits [8k+7:8k]; byte 0 is least significant.
  - When byte 3 is accepted, go to WRITE.
- WRITE (RxReady=0): exactly one cycle with WE=1.
  - WA = BASE_ADDR + 4*WordCount (value before the increment).
  - WD = the assembled word.
  - WordCount increments at the end of this cycle.
  - If the incremented count equals N: go to DONE (or CHK when the macro is set). Otherwise return to DATA.
- Latency: WE asserts in the cycle immediately after the 4th byte is accepted. Sustained rate is 4 bytes plus 1 write cycle per word.
- WE=0 in all states other than WRITE. WA and WD keep their last values when WE=0.
- DONE: Busy=0, Done=1, RxReady=0. Held until Start or Reset.
- ERR: Busy=0, Error=1, RxReady=0. Held until Start or Reset. WordCount retains the number of words already written; those writes are not undone.
- Busy=1 in LEN, DATA, WRITE and CHK.
- Address wrap: impossible, because N≤MEM_WORDS is checked in LEN. The highest address is BASE_ADDR + 4*(MEM_WORDS-1); for the defaults this is 0x1FC.
- Start together with RxValid in IDLE: only Start acts; no byte is consumed that cycle, since RxReady=0 in IDLE.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - Each frame ends with one checksum byte, equal to the 8-bit modulo-256 sum of all 4N data bytes. The count byte is excluded.
  - After the final WRITE, the loader enters CHK (RxReady=1) and accepts that byte.
  - Match: go to DONE. Mismatch: go to ERR.
  - The running sum is cleared on Start and on Reset.
- Undefined: no CHK state. The frame ends after the final WRITE, and the loader goes directly to DONE.

Test Plan:
- Reset, then Start, then bytes 02, 00,00,A0,E3, 01,10,81,E2 with RxValid held high:
  - WE at WA=0x0 with WD=E3A00000, then WE at WA=0x4 with WD=E2811001;
  - Done=1, WordCount=2, Busy=0.
- Count byte 0x00, then in a separate run count byte 0x81 (129): ERR, Error=1, WE never asserts, RxReady=0.
- Count 128 with data = word index, RxValid toggling randomly: 128 writes, last at WA=0x1FC with WD=0x0000007F; Done=1.
- Reset asserted after 2 bytes of word 3: all outputs 0, state IDLE, no write of the partial word; a following Start and a 1-word frame writes at WA=0x0.
- Start pulsed during DATA: ignored; the frame completes unchanged.
- With INSTR_LOADER_CHECKSUM_EN: 1-word frame 01,01,02,03,04 plus checksum 0A gives Done=1; checksum 0B gives Error=1 with WordCount=1.
